match_round_controller: RTL and testbench

// Top-level match sequencer for the quidditch game. Gates the player movement

---
 rtl/match_round_controller.sv | 141 ++++++++++++++
 tb/tb_match_round_controller.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/match_round_controller.sv
// Match sequencer: gates player movement, runs serve/goal frame countdowns,
// keeps both scores and declares the winner. Every output is registered.
module match_round_controller #(
    parameter int WIN_SCORE    = 5,
    parameter int SERVE_FRAMES = 120,
    parameter int GOAL_FRAMES  = 90
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start_button,
    input  logic       frame_tick,
    input  logic       goal_left,
    input  logic       goal_right,
    output logic [2:0] game_state,
    output logic       players_en,
    output logic       pos_reload,
    output logic       serve_launch,
    output logic       serve_dir,
    output logic [3:0] score_left,
    output logic [3:0] score_right,
    output logic [1:0] winner
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        PAUSE = 3'd3,
        GOAL  = 3'd4,
        OVER  = 3'd5
    } state_t;

    localparam int CMAX = (SERVE_FRAMES > GOAL_FRAMES) ? SERVE_FRAMES : GOAL_FRAMES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
    localparam logic [CW-1:0] GOAL_LAST  = CW'(GOAL_FRAMES - 1);
    localparam logic [3:0]    WIN        = 4'(WIN_SCORE);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          start_q;
    logic          rst_q;
    logic          press;

    // rst_q masks the first edge after reset release, so a button held low
    // through reset never counts as a press even though start_q resets to 1.
    assign press      = start_q & ~start_button & ~rst_q;
    assign game_state = state;

    // Match FSM with registered outputs, counter and scores.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            start_q      <= 1'b1;
            rst_q        <= 1'b1;
            players_en   <= 1'b0;
            pos_reload   <= 1'b0;
            serve_launch <= 1'b0;
            serve_dir    <= 1'b0;
            score_left   <= 4'd0;
            score_right  <= 4'd0;
            winner       <= 2'b00;
        end else begin
            start_q      <= start_button;
            rst_q        <= 1'b0;
            players_en   <= 1'b0;
            pos_reload   <= 1'b0;
            serve_launch <= 1'b0;
            case (state)
                IDLE, OVER: begin
                    if (press) begin
                        state       <= SERVE;
                        cnt         <= '0;
                        score_left  <= 4'd0;
                        score_right <= 4'd0;
                        winner      <= 2'b00;
                        serve_dir   <= 1'b0;
                        pos_reload  <= 1'b1;
                    end
                end
                SERVE: begin
                    if (frame_tick) begin
                        if (cnt == SERVE_LAST) begin
                            state        <= PLAY;
                            cnt          <= '0;
                            serve_launch <= 1'b1;
                            players_en   <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                PLAY: begin
                    // A goal always beats a coincident press.
                    if (goal_left || goal_right) begin
                        state <= GOAL;
                        cnt   <= '0;
                        if (goal_left && !goal_right) begin
                            if (score_right < WIN) score_right <= score_right + 4'd1;
                            serve_dir <= 1'b1;
                        end else if (goal_right && !goal_left) begin
                            if (score_left < WIN) score_left <= score_left + 4'd1;
                            serve_dir <= 1'b0;
                        end
                    end else if (press) begin
                        state <= PAUSE;
                        cnt   <= '0;
                    end else begin
                        players_en <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (press) begin
                        state      <= PLAY;
                        cnt        <= '0;
                        players_en <= 1'b1;
                    end
                end
                GOAL: begin
                    if (frame_tick) begin
                        if (cnt == GOAL_LAST) begin
                            cnt <= '0;
                            if (score_left == WIN || score_right == WIN) begin
                                state  <= OVER;
                                winner <= (score_left == WIN) ? 2'b01 : 2'b10;
                            end else begin
                                state      <= SERVE;
                                pos_reload <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_match_round_controller.sv
// Bench for match_round_controller: each driven cycle pushes its expected
// output word; each scenario drains and compares at its end.
module tb_match_round_controller;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                           S_PAUSE = 3'd3, S_GOAL = 3'd4, S_OVER = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_button = 1'b1;
    logic       frame_tick = 1'b0;
    logic       goal_left = 1'b0;
    logic       goal_right = 1'b0;
    logic [2:0] game_state;
    logic       players_en, pos_reload, serve_launch, serve_dir;
    logic [3:0] score_left, score_right;
    logic [1:0] winner;

    int n_chk = 0;
    int n_err = 0;

    // {state, score_left, score_right, winner, players_en, pos_reload, serve_launch, serve_dir}
    logic [16:0] exp_q[$];
    logic [16:0] obs_q[$];

    match_round_controller #(.WIN_SCORE(3), .SERVE_FRAMES(4), .GOAL_FRAMES(2)) dut (
        .clk(clk), .rst(rst), .start_button(start_button), .frame_tick(frame_tick),
        .goal_left(goal_left), .goal_right(goal_right), .game_state(game_state),
        .players_en(players_en), .pos_reload(pos_reload), .serve_launch(serve_launch),
        .serve_dir(serve_dir), .score_left(score_left), .score_right(score_right),
        .winner(winner)
    );

    always #5 clk = ~clk;

    // Drive one cycle, record the expected post-edge outputs, capture actual ones.
    task automatic drv(input logic rs, sb, tk, gl, gr,
                       input logic [2:0] st, input logic [3:0] sl, sr,
                       input logic [1:0] w, input logic en, rl, la, dir);
        rst = rs; start_button = sb; frame_tick = tk; goal_left = gl; goal_right = gr;
        exp_q.push_back({st, sl, sr, w, en, rl, la, dir});
        @(posedge clk);
        #1;
        obs_q.push_back({game_state, score_left, score_right, winner,
                         players_en, pos_reload, serve_launch, serve_dir});
        frame_tick = 1'b0; goal_left = 1'b0; goal_right = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] e, o;
        int k = 0;
        drv(1, 1, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, 0, 0);
        drv(1, 1, 1, 1, 1, S_IDLE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, S_IDLE, 0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++; k++;
            if (o !== e) begin n_err++; $display("FAIL reset step %0d: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_serve();
        logic [16:0] e, o;
        int k = 0;
        drv(0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 1, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_PLAY,  0, 0, 0, 1, 0, 1, 0);
        drv(0, 1, 0, 0, 0, S_PLAY,  0, 0, 0, 1, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++; k++;
            if (o !== e) begin n_err++; $display("FAIL serve step %0d: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_goal();
        logic [16:0] e, o;
        int k = 0;
        drv(0, 1, 0, 0, 1, S_GOAL,  1, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_GOAL,  1, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_SERVE, 1, 0, 0, 0, 1, 0, 0);
        drv(0, 1, 0, 1, 0, S_SERVE, 1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drv(0, 1, 1, 0, 0, S_SERVE, 1, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_PLAY,  1, 0, 0, 1, 0, 1, 0);
        drv(0, 1, 0, 1, 0, S_GOAL,  1, 1, 0, 0, 0, 0, 1);
        drv(0, 1, 1, 0, 0, S_GOAL,  1, 1, 0, 0, 0, 0, 1);
        drv(0, 1, 1, 0, 0, S_SERVE, 1, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) drv(0, 1, 1, 0, 0, S_SERVE, 1, 1, 0, 0, 0, 0, 1);
        drv(0, 1, 1, 0, 0, S_PLAY,  1, 1, 0, 1, 0, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++; k++;
            if (o !== e) begin n_err++; $display("FAIL goal step %0d: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_both_goals();
        logic [16:0] e, o;
        int k = 0;
        drv(0, 1, 0, 1, 1, S_GOAL,  1, 1, 0, 0, 0, 0, 1);
        drv(0, 1, 1, 0, 0, S_GOAL,  1, 1, 0, 0, 0, 0, 1);
        drv(0, 1, 1, 0, 0, S_SERVE, 1, 1, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) drv(0, 1, 1, 0, 0, S_SERVE, 1, 1, 0, 0, 0, 0, 1);
        drv(0, 1, 1, 0, 0, S_PLAY,  1, 1, 0, 1, 0, 1, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++; k++;
            if (o !== e) begin n_err++; $display("FAIL both_goals step %0d: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_pause();
        logic [16:0] e, o;
        int k = 0;
        drv(0, 0, 0, 0, 0, S_PAUSE, 1, 1, 0, 0, 0, 0, 1);
        drv(0, 1, 1, 0, 0, S_PAUSE, 1, 1, 0, 0, 0, 0, 1);
        drv(0, 1, 0, 0, 1, S_PAUSE, 1, 1, 0, 0, 0, 0, 1);
        drv(0, 0, 0, 0, 0, S_PLAY,  1, 1, 0, 1, 0, 0, 1);
        drv(0, 1, 0, 0, 0, S_PLAY,  1, 1, 0, 1, 0, 0, 1);
        drv(0, 0, 0, 0, 1, S_GOAL,  2, 1, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_GOAL,  2, 1, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_SERVE, 2, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) drv(0, 1, 1, 0, 0, S_SERVE, 2, 1, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_PLAY,  2, 1, 0, 1, 0, 1, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++; k++;
            if (o !== e) begin n_err++; $display("FAIL pause step %0d: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_win();
        logic [16:0] e, o;
        int k = 0;
        drv(0, 1, 0, 0, 1, S_GOAL,  3, 1, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_GOAL,  3, 1, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_OVER,  3, 1, 1, 0, 0, 0, 0);
        drv(0, 1, 1, 1, 1, S_OVER,  3, 1, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 1, 0, 0);
        drv(0, 1, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++; k++;
            if (o !== e) begin n_err++; $display("FAIL win step %0d: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [16:0] e, o;
        int k = 0;
        for (int i = 0; i < 3; i++) drv(0, 1, 1, 0, 0, S_SERVE, 0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_PLAY,  0, 0, 0, 1, 0, 1, 0);
        drv(0, 1, 0, 0, 1, S_GOAL,  1, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_GOAL,  1, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 1, 0, 0, S_SERVE, 1, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++)
            drv(0, 1, 1, 0, 0, (i == 3) ? S_PLAY : S_SERVE, 1, 0, 0, i == 3, 0, i == 3, 0);
        drv(1, 1, 0, 0, 0, S_IDLE,  0, 0, 0, 0, 0, 0, 0);
        drv(1, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, S_IDLE,  0, 0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, S_IDLE,  0, 0, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, S_SERVE, 0, 0, 0, 0, 1, 0, 0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_chk++; k++;
            if (o !== e) begin n_err++; $display("FAIL reset_mid step %0d: got %h want %h", k, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_goal();
        test_both_goals();
        test_pause();
        test_win();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
